// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard
//   RAW-hazard interlock that sits between ID and EX of the MIPS32 pipeline. A LAT-deep shadow
//   pipe records the destination register of every issued writing instruction. Decode is held
//   while any used source register matches a pending write. The oldest stage reports writeback.
//
// Ports
//   clk, rst                     pipeline clock (rising edge); asynchronous active-high reset
//   id_valid                     decode holds a valid instruction
//   id_rs, id_rt                 source registers
//   id_rs_used, id_rt_used       source-read qualifiers
//   id_we, id_rd                 destination write enable and register
//   flush                        kill the youngest FLUSH_D shadow stages; block issue
//   stall                        combinational decode hold
//   issue                        combinational id_valid & ~stall & ~flush
//   wb_valid, wb_rd              registered writeback report from the oldest stage
//   inflight                     number of valid shadow stages
//   stall_cnt                    saturating count of stall cycles since reset
module mips_hazard_scoreboard #(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned LAT       = 3,
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned FLUSH_D   = 2,
    parameter int unsigned CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_we,
    input  logic [AW-1:0] id_rd,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [AW:0]   inflight,
    output logic [CW-1:0] stall_cnt
);

    // Stages compared against decode sources. With bypass, the WB stage writes the regfile
    // before decode reads it, so it is excluded from the window.
    localparam int HazDepth  = (WB_BYPASS != 0) ? int'(LAT) - 1 : int'(LAT);
    // Flush can never kill more stages than exist.
    localparam int KillDepth = (FLUSH_D > LAT) ? int'(LAT) : int'(FLUSH_D);
    localparam logic [AW:0] NregsW = (AW+1)'(NREGS);

    // Index 0 is stage 1 (youngest), index LAT-1 is stage LAT (writeback).
    logic [LAT-1:0] v_q, v_d;
    logic [AW-1:0]  rd_q [LAT];
    logic [AW-1:0]  rd_d [LAT];
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;

    logic rs_chk, rt_chk, rd_ok, hazard, wr_ok;

    // R0 and registers beyond NREGS are never tracked and never compared.
    always_comb begin
        rs_chk = id_rs_used && (id_rs != '0) && ({1'b0, id_rs} < NregsW);
        rt_chk = id_rt_used && (id_rt != '0) && ({1'b0, id_rt} < NregsW);
        rd_ok  = (id_rd != '0) && ({1'b0, id_rd} < NregsW);
    end

    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < int'(LAT); k++) begin
            if (k < HazDepth && v_q[k]) begin
                if (rs_chk && rd_q[k] == id_rs) hazard = 1'b1;
                if (rt_chk && rd_q[k] == id_rt) hazard = 1'b1;
            end
        end
    end

    always_comb begin
        stall = id_valid & hazard;
        issue = id_valid & ~stall & ~flush;
        wr_ok = issue & id_we & rd_ok;
    end

    // Shift the shadow pipe. A flush kills whatever currently sits in stages 1..FLUSH_D, so
    // their contents do not advance; older stages keep moving toward writeback. Invalid
    // entries always carry rd=0 so wb_rd is zero whenever wb_valid is low.
    always_comb begin
        v_d[0]  = wr_ok;
        rd_d[0] = wr_ok ? id_rd : '0;
        for (int k = 1; k < int'(LAT); k++) begin
            if (flush && k <= KillDepth) begin
                v_d[k]  = 1'b0;
                rd_d[k] = '0;
            end else begin
                v_d[k]  = v_q[k-1];
                rd_d[k] = rd_q[k-1];
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CW{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < int'(LAT); k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < int'(LAT); k++) begin
                rd_q[k] <= rd_d[k];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < int'(LAT); k++) begin
            inflight = inflight + {{AW{1'b0}}, v_q[k]};
        end
    end

    assign wb_valid  = v_q[LAT-1];
    assign wb_rd     = rd_q[LAT-1];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Randomised bench for mips_hazard_scoreboard (LAT=3, bypass on, FLUSH_D=2, CW=5 so the
// stall counter saturates). A list of in-flight writes with their issue cycles forms the
// reference; expected writebacks are queued at issue and popped by an independent monitor.
module tb_mips_hazard_scoreboard;

    localparam int AW  = 5;
    localparam int LAT = 3;
    localparam int FD  = 2;
    localparam int CW  = 5;
    localparam int WIN = LAT - 1;
    localparam int SAT = (1 << CW) - 1;

    logic          clk, rst;
    logic          id_valid, id_rs_used, id_rt_used, id_we, flush;
    logic [AW-1:0] id_rs, id_rt, id_rd;
    logic          stall, issue, wb_valid;
    logic [AW-1:0] wb_rd;
    logic [AW:0]   inflight;
    logic [CW-1:0] stall_cnt;

    mips_hazard_scoreboard #(
        .NREGS(32), .AW(AW), .LAT(LAT), .WB_BYPASS(1), .FLUSH_D(FD), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_rd(id_rd),
        .flush(flush), .stall(stall), .issue(issue), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .inflight(inflight), .stall_cnt(stall_cnt)
    );

    typedef struct {
        int rd;
        int ic;
    } wr_t;

    wr_t live[$];   // writes still inside the pipe, for hazard and inflight prediction
    wr_t sbq[$];    // expected writebacks, consumed by the monitor
    int  cyc = 0;
    int  scnt = 0;
    int  n_checks = 0;
    int  n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every writeback must match the oldest expected entry, at the right cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wb_valid) begin
                    if (sbq.size() == 0) begin
                        chk("wb_unexpected", 1, 0);
                    end else begin
                        chk("wb_rd", int'(wb_rd), sbq[0].rd);
                        chk("wb_cycle", cyc, sbq[0].ic + LAT);
                        void'(sbq.pop_front());
                    end
                end else begin
                    chk("wb_rd_idle", int'(wb_rd), 0);
                    if (sbq.size() > 0 && sbq[0].ic + LAT <= cyc) begin
                        chk("wb_missing", 0, sbq[0].rd);
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    // One decode cycle: drive, compare combinational and counter outputs, advance the model.
    task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                        input bit we, input int rd, input bit fl, input bit do_rst,
                        output bit stalled);
        bit hz, st, is;
        int inf, age;
        @(negedge clk);
        id_valid = v;  id_rs = AW'(rs);  id_rt = AW'(rt);
        id_rs_used = rsu;  id_rt_used = rtu;  id_we = we;  id_rd = AW'(rd);  flush = fl;
        #1;
        hz = 1'b0;
        inf = 0;
        foreach (live[i]) begin
            age = cyc - live[i].ic;
            if (age >= 1 && age <= LAT) inf++;
            if (age >= 1 && age <= WIN) begin
                if (rsu && rs != 0 && live[i].rd == rs) hz = 1'b1;
                if (rtu && rt != 0 && live[i].rd == rt) hz = 1'b1;
            end
        end
        st = v && hz;
        is = v && !st && !fl;
        chk("stall", int'(stall), int'(st));
        chk("issue", int'(issue), int'(is));
        chk("inflight", int'(inflight), inf);
        chk("stall_cnt", int'(stall_cnt), scnt);
        stalled = st;
        if (do_rst) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_stall", int'(stall), 0);
            chk("rst_issue", int'(issue), int'(v && !fl));
            chk("rst_inflight", int'(inflight), 0);
            chk("rst_stall_cnt", int'(stall_cnt), 0);
            chk("rst_wb_valid", int'(wb_valid), 0);
            live.delete();
            sbq.delete();
            scnt = 0;
            id_valid = 1'b0;
            flush = 1'b0;
            @(posedge clk);
            #1 rst = 1'b0;
            stalled = 1'b0;
        end else begin
            if (fl) begin
                for (int i = live.size() - 1; i >= 0; i--) begin
                    age = cyc - live[i].ic;
                    if (age >= 1 && age <= FD) live.delete(i);
                end
                for (int i = sbq.size() - 1; i >= 0; i--) begin
                    age = cyc - sbq[i].ic;
                    if (age >= 1 && age <= FD) sbq.delete(i);
                end
            end
            for (int i = live.size() - 1; i >= 0; i--) begin
                if (cyc - live[i].ic >= LAT) live.delete(i);
            end
            if (is && we && rd != 0) begin
                live.push_back('{rd: rd, ic: cyc});
                sbq.push_back('{rd: rd, ic: cyc});
            end
            if (st && scnt < SAT) scnt++;
        end
    endtask

    // Present an instruction and hold it in decode until the model says it issues.
    task automatic op(input int rs, input int rt, input bit rsu, input bit rtu, input bit we,
                      input int rd);
        bit s;
        int n;
        n = 0;
        do begin
            step(1'b1, rs, rt, rsu, rtu, we, rd, 1'b0, 1'b0, s);
            n++;
        end while (s && n < 2 * LAT + 2);
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, s);
    endtask

    initial begin
        bit s, hold, cv, crsu, crtu, cwe, cfl, crst;
        int crs, crt, crd;
        rst = 1'b1;
        id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_we = 1'b0; id_rd = '0; flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_wb_valid", int'(wb_valid), 0);
        chk("reset_wb_rd", int'(wb_rd), 0);
        chk("reset_inflight", int'(inflight), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_stall", int'(stall), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Dependent pair: reader of R3 stalls two cycles.
        op(1, 2, 1'b1, 1'b1, 1'b1, 3);
        op(3, 3, 1'b1, 1'b1, 1'b1, 4);
        idle(LAT + 1);
        chk("t1_stall_cnt", int'(stall_cnt), 2);

        // Independent stream fills the pipe.
        op(1, 0, 1'b1, 1'b0, 1'b1, 5);
        op(2, 0, 1'b1, 1'b0, 1'b1, 6);
        op(8, 0, 1'b1, 1'b0, 1'b1, 7);
        idle(LAT + 1);

        // R0 is never tracked.
        op(1, 2, 1'b1, 1'b1, 1'b1, 0);
        op(0, 0, 1'b1, 1'b1, 1'b1, 11);
        idle(LAT + 1);

        // Two writes killed by a flush, then a reader of R9.
        op(1, 0, 1'b1, 1'b0, 1'b1, 9);
        op(1, 0, 1'b1, 1'b0, 1'b1, 10);
        step(1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 12, 1'b1, 1'b0, s);
        op(9, 10, 1'b1, 1'b1, 1'b0, 0);
        idle(LAT + 1);

        // Reset while a reader of R3 is stalled; it issues right after release.
        op(1, 2, 1'b1, 1'b1, 1'b1, 3);
        step(1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b1, s);
        op(3, 0, 1'b1, 1'b0, 1'b1, 4);
        idle(LAT + 1);

        // Random traffic over a small register set to provoke hazards.
        hold = 1'b0;
        cv = 1'b0; crs = 0; crt = 0; crsu = 1'b0; crtu = 1'b0; cwe = 1'b0; crd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold) begin
                cv   = ($urandom_range(0, 9) < 8);
                crs  = int'($urandom_range(0, 7));
                crt  = int'($urandom_range(0, 7));
                crsu = $urandom_range(0, 3) != 0;
                crtu = $urandom_range(0, 1) != 0;
                cwe  = $urandom_range(0, 3) != 0;
                crd  = int'($urandom_range(0, 7));
            end
            cfl  = ($urandom_range(0, 11) == 0);
            crst = hold && ($urandom_range(0, 149) == 0);
            step(cv, crs, crt, crsu, crtu, cwe, crd, cfl, crst, s);
            hold = s && !cfl;
        end

        idle(LAT + 2);
        chk("sb_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
